tape_block_capture: RTL and testbench
=====================================

Name: tape_block_capture

Overview:
- Parametrised successor to the single-stream tape byte capture.
- Assembles decoded tape bits into bytes in configurable bit order and writes them to a 2**ADDR_W-byte tape RAM.
- Frames the stream into tape blocks: sync starts a block, end-of-block closes it.
- Reports per-block start, length, XOR checksum status and truncation. Can stop or wrap at memory end, and can roll back bad blocks. Sits between tape_bit_reader and tape_mem, feeding the loader's block directory.

Parameters:
- ADDR_W, 13, RAM address width; DEPTH = 2**ADDR_W bytes.
- MSB_FIRST, 1, 1: first bit of a byte lands in bit 7; 0: first bit lands in bit 0.
- WRAP, 0, 0: stop at memory end; 1: pointer wraps to 0, never full.
- DROP_BAD, 1, 1: a block closing with a failed checksum or truncation rewinds wr_ptr to its block_start.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of pointers, counters, flags; returns to IDLE
- start  in  1  sync detected; opens a block
- block_end  in  1  1-cycle pulse, end of block (tone loss)
- data_bit  in  1  decoded bit
- data_valid  in  1  1-cycle pulse, data_bit valid
- mem_we  out  1  RAM write enable (combinational)
- mem_waddr  out  ADDR_W  RAM write address (= wr_ptr)
- mem_wdata  out  8  assembled byte including the current bit
- byte_written  out  1  registered pulse, cycle after mem_we
- mem_full  out  1  sticky full flag (WRAP=0 only)
- wr_ptr_out  out  ADDR_W  current write pointer
- capturing  out  1  high in CAPTURE
- block_done  out  1  1-cycle pulse, block closed
- block_start  out  ADDR_W  start address of closed block
- block_len  out  ADDR_W+1  bytes in closed block
- block_chk_ok  out  1  XOR of all bytes == 0 and len >= 2 and not truncated
- block_partial  out  1  closed block had a dangling partial byte
- block_trunc  out  1  block stopped by full (WRAP=0) or exceeded DEPTH (WRAP=1)
- block_count  out  8  accepted blocks, saturating at 255
- led_bit  out  1  toggles on every accepted bit

Behaviour:
- Reset and clear zero every output, the pointers, bit counter, shift register and running XOR. State goes to IDLE.
- States: IDLE, CAPTURE, FULL.
  - IDLE: start -> CAPTURE. The block base is latched as block_start = wr_ptr; len, XOR and bit count are zeroed.
  - CAPTURE: start is ignored. block_end -> IDLE via block close. Writing address DEPTH-1 with WRAP=0 -> FULL, with immediate block close and trunc=1.
  - FULL: all bits are ignored; block_end and start are ignored. Only clear or reset leaves FULL.
- Bit accept happens only in CAPTURE with data_valid. The bit goes to position (MSB_FIRST ? 7-bit_cnt : bit_cnt), bit_cnt increments, and led_bit toggles.
- On the 8th bit:
  - mem_we=1 in the same cycle, with mem_wdata holding the complete byte and mem_waddr = wr_ptr.
  - Next cycle: byte_written=1, wr_ptr+1 (mod DEPTH), len+1 (saturating at DEPTH), XOR ^= byte, shift register cleared.
- data_valid in the same cycle as block_end: the bit is processed first. If it completes a byte, the byte is written and counted in the closing block.
- Block close: block_done pulses the cycle after the close event, and the block_* outputs hold until the next close.
  - A nonzero bit_cnt at close sets block_partial=1; the partial byte is discarded.
  - len == 0 (noise) gives no block_done and no count change.
  - block_count increments only if chk_ok, or if DROP_BAD=0.
  - DROP_BAD=1 with !chk_ok: wr_ptr and wr_ptr_out rewind to block_start in the close cycle. mem_full stays set if already set.
- WRAP=1: mem_full is never asserted. Once len reaches DEPTH, trunc=1 on close.
- clear has priority over all other inputs in the same cycle.
- Reset mid-block aborts it with no block_done.

Test Plan:
- MSB_FIRST=1: start, bits 1,0,1,0,0,1,0,1, block_end -> mem_we at addr 0 with data 0xA5; block_done with len=1, chk_ok=0, partial=0; count unchanged (DROP_BAD=1), wr_ptr back to 0.
- start, bytes 0xFF,0x12,0xED, block_end -> block_done with start=0, len=3, chk_ok=1; block_count=1; wr_ptr_out=3.
- 2nd block 0x00,0x55 plus 3 extra bits, then block_end -> partial=1, chk_ok=0, wr_ptr rewinds to 3, block_count stays 1.
- ADDR_W=4, WRAP=0: start plus 16 bytes -> 16th write at addr 15, mem_full=1, block_done with trunc=1; further bits give no mem_we until clear.
- ADDR_W=4, WRAP=1: 20 bytes -> writes to addrs 0..15 then 0..3; mem_full=0; close gives len=16, trunc=1.
- data_valid on the 8th bit in the same cycle as block_end -> byte written and counted in len; start during CAPTURE ignored; reset mid-block -> no block_done, all outputs 0.

Source files
------------

// File: rtl/tape_block_capture_if.sv
// Tape block capture bus.
// Groups the decoded bit stream coming from the bit reader, the RAM write
// port going to tape memory and the per-block report going to the loader's
// block directory.
//   start, block_end, data_bit, data_valid : bit stream into the capture block
//   mem_we, mem_waddr, mem_wdata           : RAM write port
//   byte_written, mem_full, wr_ptr_out     : write progress
//   capturing, led_bit                     : status
//   block_done, block_start, block_len,
//   block_chk_ok, block_partial,
//   block_trunc, block_count               : closed-block report
interface tape_block_capture_if #(
  parameter int ADDR_W = 13
) ();
  logic              start;
  logic              block_end;
  logic              data_bit;
  logic              data_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              byte_written;
  logic              mem_full;
  logic [ADDR_W-1:0] wr_ptr_out;
  logic              capturing;
  logic              block_done;
  logic [ADDR_W-1:0] block_start;
  logic [ADDR_W:0]   block_len;
  logic              block_chk_ok;
  logic              block_partial;
  logic              block_trunc;
  logic [7:0]        block_count;
  logic              led_bit;

  // Bit reader / loader side.
  modport master (
    output start, block_end, data_bit, data_valid,
    input  mem_we, mem_waddr, mem_wdata, byte_written, mem_full, wr_ptr_out,
    input  capturing, block_done, block_start, block_len, block_chk_ok,
    input  block_partial, block_trunc, block_count, led_bit
  );

  // Capture block side.
  modport slave (
    input  start, block_end, data_bit, data_valid,
    output mem_we, mem_waddr, mem_wdata, byte_written, mem_full, wr_ptr_out,
    output capturing, block_done, block_start, block_len, block_chk_ok,
    output block_partial, block_trunc, block_count, led_bit
  );
endinterface

// File: rtl/tape_block_capture.sv
// Tape block capture.
// Assembles decoded tape bits into bytes, writes them into a 2**ADDR_W byte
// tape RAM and frames the stream into blocks (sync opens, tone loss closes).
// Each closed block reports start address, length, XOR checksum status,
// dangling partial byte and truncation. Bad blocks may be rolled back.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   clear   : synchronous clear of pointers, counters and flags
//   bus     : tape_block_capture_if.slave (stream in, RAM port, block report)
module tape_block_capture #(
  parameter int ADDR_W    = 13,
  parameter int MSB_FIRST = 1,
  parameter int WRAP      = 0,
  parameter int DROP_BAD  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  tape_block_capture_if.slave   bus
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LEN_TWO   = (ADDR_W+1)'(2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FULL
  } state_t;

  state_t            state_reg, state_next;
  logic [2:0]        bit_cnt_reg;
  logic [7:0]        shift_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] blk_base_reg;
  logic [ADDR_W:0]   len_reg;
  logic [7:0]        xor_reg;
  logic              byte_written_reg;
  logic              mem_full_reg;
  logic              block_done_reg;
  logic [ADDR_W-1:0] block_start_reg;
  logic [ADDR_W:0]   block_len_reg;
  logic              block_chk_ok_reg;
  logic              block_partial_reg;
  logic              block_trunc_reg;
  logic [7:0]        block_count_reg;
  logic              led_bit_reg;

  logic              open_blk;
  logic              accept;
  logic [2:0]        bit_pos;
  logic [2:0]        bit_cnt_next;
  logic [7:0]        byte_cur;
  logic              byte_done;
  logic              hit_end;
  logic [ADDR_W:0]   len_new;
  logic [7:0]        xor_new;
  logic              trunc_new;
  logic              chk_new;
  logic              partial_new;
  logic              close_blk;
  logic              good_close;
  logic              rewind;

  // Next-state and datapath decode. clear overrides every other input.
  always_comb begin
    state_next   = state_reg;
    open_blk     = 1'b0;
    accept       = 1'b0;
    close_blk    = 1'b0;
    bit_pos      = (MSB_FIRST != 0) ? (3'd7 - bit_cnt_reg) : bit_cnt_reg;
    byte_cur     = shift_reg;
    byte_done    = 1'b0;
    hit_end      = 1'b0;

    if (!clear) begin
      open_blk = (state_reg == ST_IDLE) && bus.start;
      accept   = (state_reg == ST_CAPTURE) && bus.data_valid;
    end

    // The shift register holds zeros in unfilled slots, so OR-in is enough.
    if (accept && bus.data_bit) begin
      byte_cur = shift_reg | (8'b1 << bit_pos);
    end
    bit_cnt_next = accept ? (bit_cnt_reg + 3'd1) : bit_cnt_reg;
    byte_done    = accept && (bit_cnt_reg == 3'd7);
    hit_end      = (WRAP == 0) && byte_done && (wr_ptr_reg == ADDR_MAX);

    // Block figures as they stand after this cycle's bit, so a byte
    // completed together with block_end is counted in the closing block.
    len_new     = len_reg;
    xor_new     = xor_reg;
    if (byte_done) begin
      len_new = (len_reg == DEPTH_LEN) ? len_reg : (len_reg + LEN_ONE);
      xor_new = xor_reg ^ byte_cur;
    end
    trunc_new   = hit_end || ((WRAP != 0) && (len_new == DEPTH_LEN));
    chk_new     = (xor_new == 8'h00) && (len_new >= LEN_TWO) && !trunc_new;
    partial_new = (bit_cnt_next != 3'd0);

    if (!clear && (state_reg == ST_CAPTURE)) begin
      close_blk = bus.block_end || hit_end;
    end
    // A block with no complete byte is treated as noise and not reported.
    good_close = close_blk && (len_new != '0);
    rewind     = good_close && (DROP_BAD != 0) && !chk_new;

    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:    if (bus.start) state_next = ST_CAPTURE;
        ST_CAPTURE: begin
          if (hit_end)            state_next = ST_FULL;
          else if (bus.block_end) state_next = ST_IDLE;
        end
        ST_FULL:    state_next = ST_FULL;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= ST_IDLE;
      bit_cnt_reg       <= '0;
      shift_reg         <= '0;
      wr_ptr_reg        <= '0;
      blk_base_reg      <= '0;
      len_reg           <= '0;
      xor_reg           <= '0;
      byte_written_reg  <= 1'b0;
      mem_full_reg      <= 1'b0;
      block_done_reg    <= 1'b0;
      block_start_reg   <= '0;
      block_len_reg     <= '0;
      block_chk_ok_reg  <= 1'b0;
      block_partial_reg <= 1'b0;
      block_trunc_reg   <= 1'b0;
      block_count_reg   <= '0;
      led_bit_reg       <= 1'b0;
    end else if (clear) begin
      state_reg         <= ST_IDLE;
      bit_cnt_reg       <= '0;
      shift_reg         <= '0;
      wr_ptr_reg        <= '0;
      blk_base_reg      <= '0;
      len_reg           <= '0;
      xor_reg           <= '0;
      byte_written_reg  <= 1'b0;
      mem_full_reg      <= 1'b0;
      block_done_reg    <= 1'b0;
      block_start_reg   <= '0;
      block_len_reg     <= '0;
      block_chk_ok_reg  <= 1'b0;
      block_partial_reg <= 1'b0;
      block_trunc_reg   <= 1'b0;
      block_count_reg   <= '0;
      led_bit_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      byte_written_reg <= byte_done;
      block_done_reg   <= good_close;

      if (accept) begin
        led_bit_reg <= ~led_bit_reg;
      end

      if (open_blk) begin
        bit_cnt_reg  <= '0;
        shift_reg    <= '0;
        len_reg      <= '0;
        xor_reg      <= '0;
        blk_base_reg <= wr_ptr_reg;
      end else if (close_blk) begin
        // Any dangling partial byte is discarded here.
        bit_cnt_reg <= '0;
        shift_reg   <= '0;
        len_reg     <= len_new;
        xor_reg     <= xor_new;
      end else begin
        bit_cnt_reg <= bit_cnt_next;
        shift_reg   <= byte_done ? 8'h00 : byte_cur;
        len_reg     <= len_new;
        xor_reg     <= xor_new;
      end

      // Rollback wins over the increment of a byte written in the close cycle.
      if (rewind) begin
        wr_ptr_reg <= blk_base_reg;
      end else if (byte_done) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end

      if (hit_end) begin
        mem_full_reg <= 1'b1;
      end

      if (good_close) begin
        block_start_reg   <= blk_base_reg;
        block_len_reg     <= len_new;
        block_chk_ok_reg  <= chk_new;
        block_partial_reg <= partial_new;
        block_trunc_reg   <= trunc_new;
        if ((chk_new || (DROP_BAD == 0)) && (block_count_reg != 8'hFF)) begin
          block_count_reg <= block_count_reg + 8'd1;
        end
      end
    end
  end

  assign bus.mem_we        = byte_done;
  assign bus.mem_waddr     = wr_ptr_reg;
  assign bus.mem_wdata     = byte_cur;
  assign bus.byte_written  = byte_written_reg;
  assign bus.mem_full      = mem_full_reg;
  assign bus.wr_ptr_out    = wr_ptr_reg;
  assign bus.capturing     = (state_reg == ST_CAPTURE);
  assign bus.block_done    = block_done_reg;
  assign bus.block_start   = block_start_reg;
  assign bus.block_len     = block_len_reg;
  assign bus.block_chk_ok  = block_chk_ok_reg;
  assign bus.block_partial = block_partial_reg;
  assign bus.block_trunc   = block_trunc_reg;
  assign bus.block_count   = block_count_reg;
  assign bus.led_bit       = led_bit_reg;

endmodule

// File: tb/tb_tape_block_capture.sv
// Directed bench for tape_block_capture.
// Three instances share one bit stream: a default-size capture (dut0), a
// 16-byte stop-at-end capture (dut1) and a 16-byte wrapping capture (dut2).
module tb_tape_block_capture;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic block_end = 1'b0;
  logic data_bit = 1'b0;
  logic data_valid = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tape_block_capture_if #(.ADDR_W(13)) bus0 ();
  tape_block_capture_if #(.ADDR_W(4))  bus1 ();
  tape_block_capture_if #(.ADDR_W(4))  bus2 ();

  assign bus0.start = start;  assign bus0.block_end = block_end;
  assign bus0.data_bit = data_bit;  assign bus0.data_valid = data_valid;
  assign bus1.start = start;  assign bus1.block_end = block_end;
  assign bus1.data_bit = data_bit;  assign bus1.data_valid = data_valid;
  assign bus2.start = start;  assign bus2.block_end = block_end;
  assign bus2.data_bit = data_bit;  assign bus2.data_valid = data_valid;

  tape_block_capture #(.ADDR_W(13), .MSB_FIRST(1), .WRAP(0), .DROP_BAD(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus0.slave));
  tape_block_capture #(.ADDR_W(4), .MSB_FIRST(1), .WRAP(0), .DROP_BAD(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus1.slave));
  tape_block_capture #(.ADDR_W(4), .MSB_FIRST(1), .WRAP(1), .DROP_BAD(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus2.slave));

  // Write recorders for the two small instances.
  logic rec_en = 1'b0;
  int   w1_cnt = 0;
  int   w1_last = -1;
  int   w2_addr[$];

  always @(negedge clk) begin
    if (rec_en) begin
      if (bus1.mem_we) begin
        w1_cnt  = w1_cnt + 1;
        w1_last = int'(bus1.mem_waddr);
      end
      if (bus2.mem_we) begin
        w2_addr.push_back(int'(bus2.mem_waddr));
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_end();
    block_end = 1'b1;
    tick();
    block_end = 1'b0;
  endtask

  // Sends one byte MSB first; optionally checks dut0's write on the 8th bit.
  task automatic send_byte(input logic [7:0] b, input bit chk, input int exp_addr);
    for (int i = 7; i >= 0; i--) begin
      data_bit   = b[i];
      data_valid = 1'b1;
      if (i == 0 && chk) begin
        #1;
        check("mem_we", 32'(bus0.mem_we), 32'd1);
        check("mem_waddr", 32'(bus0.mem_waddr), 32'(exp_addr));
        check("mem_wdata", 32'(bus0.mem_wdata), 32'(b));
      end
      tick();
    end
    data_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    data_bit   = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] v;

    // Reset state
    tick();
    tick();
    check("rst wr_ptr", 32'(bus0.wr_ptr_out), 32'd0);
    check("rst count", 32'(bus0.block_count), 32'd0);
    check("rst capturing", 32'(bus0.capturing), 32'd0);
    check("rst done", 32'(bus0.block_done), 32'd0);
    check("rst full", 32'(bus0.mem_full), 32'd0);
    check("rst led", 32'(bus0.led_bit), 32'd0);
    check("rst len", 32'(bus0.block_len), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single byte 0xA5: too short for a good checksum, rolled back
    pulse_start();
    check("t1 capturing", 32'(bus0.capturing), 32'd1);
    send_byte(8'hA5, 1'b1, 0);
    check("t1 byte_written", 32'(bus0.byte_written), 32'd1);
    check("t1 wr_ptr", 32'(bus0.wr_ptr_out), 32'd1);
    pulse_end();
    check("t1 done", 32'(bus0.block_done), 32'd1);
    check("t1 len", 32'(bus0.block_len), 32'd1);
    check("t1 chk_ok", 32'(bus0.block_chk_ok), 32'd0);
    check("t1 partial", 32'(bus0.block_partial), 32'd0);
    check("t1 count", 32'(bus0.block_count), 32'd0);
    check("t1 wr_ptr rewind", 32'(bus0.wr_ptr_out), 32'd0);
    tick();
    check("t1 done pulse", 32'(bus0.block_done), 32'd0);
    check("t1 idle", 32'(bus0.capturing), 32'd0);

    // Good block FF 12 ED (XOR = 0)
    pulse_start();
    send_byte(8'hFF, 1'b1, 0);
    send_byte(8'h12, 1'b1, 1);
    send_byte(8'hED, 1'b1, 2);
    pulse_end();
    check("t2 done", 32'(bus0.block_done), 32'd1);
    check("t2 start", 32'(bus0.block_start), 32'd0);
    check("t2 len", 32'(bus0.block_len), 32'd3);
    check("t2 chk_ok", 32'(bus0.block_chk_ok), 32'd1);
    check("t2 count", 32'(bus0.block_count), 32'd1);
    check("t2 wr_ptr", 32'(bus0.wr_ptr_out), 32'd3);

    // 00 55 + 3 bits, with a stray start mid-block
    pulse_start();
    send_byte(8'h00, 1'b1, 3);
    pulse_start();
    send_byte(8'h55, 1'b1, 4);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    pulse_end();
    check("t3 done", 32'(bus0.block_done), 32'd1);
    check("t3 start", 32'(bus0.block_start), 32'd3);
    check("t3 len", 32'(bus0.block_len), 32'd2);
    check("t3 partial", 32'(bus0.block_partial), 32'd1);
    check("t3 chk_ok", 32'(bus0.block_chk_ok), 32'd0);
    check("t3 count", 32'(bus0.block_count), 32'd1);
    check("t3 wr_ptr rewind", 32'(bus0.wr_ptr_out), 32'd3);
    check("t3 led", 32'(bus0.led_bit), 32'd1);

    // 3C 3C with the last bit arriving together with block_end
    pulse_start();
    send_byte(8'h3C, 1'b1, 3);
    v = 8'h3C;
    for (int i = 7; i >= 1; i--) begin
      send_bit(v[i]);
    end
    data_bit   = v[0];
    data_valid = 1'b1;
    block_end  = 1'b1;
    #1;
    check("t4 mem_we", 32'(bus0.mem_we), 32'd1);
    check("t4 mem_waddr", 32'(bus0.mem_waddr), 32'd4);
    check("t4 mem_wdata", 32'(bus0.mem_wdata), 32'h3C);
    tick();
    data_valid = 1'b0;
    block_end  = 1'b0;
    check("t4 done", 32'(bus0.block_done), 32'd1);
    check("t4 len", 32'(bus0.block_len), 32'd2);
    check("t4 chk_ok", 32'(bus0.block_chk_ok), 32'd1);
    check("t4 partial", 32'(bus0.block_partial), 32'd0);
    check("t4 count", 32'(bus0.block_count), 32'd2);
    check("t4 wr_ptr", 32'(bus0.wr_ptr_out), 32'd5);
    check("t4 start", 32'(bus0.block_start), 32'd3);

    // Reset in the middle of a block
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5 done", 32'(bus0.block_done), 32'd0);
    check("t5 count", 32'(bus0.block_count), 32'd0);
    check("t5 wr_ptr", 32'(bus0.wr_ptr_out), 32'd0);
    check("t5 capturing", 32'(bus0.capturing), 32'd0);
    check("t5 led", 32'(bus0.led_bit), 32'd0);
    check("t5 len", 32'(bus0.block_len), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("t5 no done", 32'(bus0.block_done), 32'd0);

    // 16-byte memories: stop at end versus wrap
    rec_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i * 7 + 1), 1'b0, 0);
    end
    check("t6 full", 32'(bus1.mem_full), 32'd1);
    check("t6 done", 32'(bus1.block_done), 32'd1);
    check("t6 trunc", 32'(bus1.block_trunc), 32'd1);
    check("t6 len", 32'(bus1.block_len), 32'd16);
    check("t6 chk_ok", 32'(bus1.block_chk_ok), 32'd0);
    check("t6 capturing", 32'(bus1.capturing), 32'd0);
    check("t6 wr_ptr rewind", 32'(bus1.wr_ptr_out), 32'd0);
    check("t6 wrap capturing", 32'(bus2.capturing), 32'd1);
    for (int i = 16; i < 20; i++) begin
      send_byte(8'(i * 7 + 1), 1'b0, 0);
    end
    pulse_end();
    check("t7 done", 32'(bus2.block_done), 32'd1);
    check("t7 len", 32'(bus2.block_len), 32'd16);
    check("t7 trunc", 32'(bus2.block_trunc), 32'd1);
    check("t7 full", 32'(bus2.mem_full), 32'd0);
    check("t7 chk_ok", 32'(bus2.block_chk_ok), 32'd0);
    check("t7 wr_ptr rewind", 32'(bus2.wr_ptr_out), 32'd0);
    tick();
    rec_en = 1'b0;
    check("t6 write count", 32'(w1_cnt), 32'd16);
    check("t6 last addr", 32'(w1_last), 32'd15);
    check("t6 still full", 32'(bus1.mem_full), 32'd1);
    check("t7 write count", 32'(w2_addr.size()), 32'd20);
    for (int i = 0; i < w2_addr.size(); i++) begin
      check($sformatf("t7 addr[%0d]", i), 32'(w2_addr[i]), 32'(i % 16));
    end

    // clear leaves FULL
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t8 full", 32'(bus1.mem_full), 32'd0);
    check("t8 len", 32'(bus1.block_len), 32'd0);
    check("t8 capturing", 32'(bus1.capturing), 32'd0);
    pulse_start();
    send_byte(8'h5A, 1'b0, 0);
    check("t8 wr_ptr", 32'(bus1.wr_ptr_out), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
